// File: rtl/sap_pkg.sv
// Shared SAP definitions: control-word bit positions, opcodes and the idle word.
// Imported by the datapath and by the control sequencer.
package sap_pkg;

  localparam int unsigned CTRL_W = 15;

  localparam int unsigned C_P  = 14;
  localparam int unsigned E_P  = 13;
  localparam int unsigned L_P  = 12;
  localparam int unsigned L_MA = 11;
  localparam int unsigned L_MD = 10;
  localparam int unsigned CE   = 9;
  localparam int unsigned L_R  = 8;
  localparam int unsigned L_I  = 7;
  localparam int unsigned E_I  = 6;
  localparam int unsigned L_A  = 5;
  localparam int unsigned E_A  = 4;
  localparam int unsigned S_U  = 3;
  localparam int unsigned E_U  = 2;
  localparam int unsigned L_B  = 1;
  localparam int unsigned L_O  = 0;

  // Active-low controls parked high, active-high controls low.
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 15'h0FE3;

  typedef enum logic [3:0] {
    HLT = 4'd0,
    NOP = 4'd1,
    ADD = 4'd2,
    SUB = 4'd3,
    LDA = 4'd4,
    OUT = 4'd5,
    STA = 4'd6,
    JMP = 4'd7
  } opcode_e;

endpackage

// File: rtl/sap_alu.sv
// Combinational adder/subtractor for the SAP datapath.
// Subtraction is A + ~B + 1, so carry is the not-borrow.
module sap_alu #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  assign sum    = {1'b0, a} + {1'b0, (sub ? ~b : b)} + (DATA_W+1)'(sub);
  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];
  assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// SAP execution datapath: registers, RAM and ALU on one shared bus,
// steered by the sequencer's control word; host port preloads RAM.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [14:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic              flag_c,
  output logic              flag_z,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              bus_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] mdr, ir, a_reg, b_reg, out_reg;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bus, ram_rd, alu_res;
  logic              alu_c, alu_z;
  logic              drv_p, drv_ram, drv_ir, drv_a, drv_u;
  logic [2:0]        n_drv;

  assign drv_p   = ctrl[E_P];
  assign drv_ram = ~ctrl[CE];
  assign drv_ir  = ~ctrl[E_I];
  assign drv_a   = ctrl[E_A];
  assign drv_u   = ctrl[E_U];

  assign n_drv = 3'(drv_p) + 3'(drv_ram) + 3'(drv_ir) + 3'(drv_a) + 3'(drv_u);
  assign bus_conflict = (n_drv > 3'd1);

  assign ram_rd = mem[mar];

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (a_reg),
    .b      (b_reg),
    .sub    (ctrl[S_U]),
    .result (alu_res),
    .carry  (alu_c),
    .zero   (alu_z)
  );

  // Priority mux keeps the bus defined even when drivers collide.
  always_comb begin
    bus = '0;
    if (drv_u)        bus = alu_res;
    else if (drv_a)   bus = a_reg;
    else if (drv_ram) bus = ram_rd;
    else if (drv_ir)  bus = DATA_W'(ir[ADDR_W-1:0]);
    else if (drv_p)   bus = DATA_W'(pc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      mar     <= '0;
      mdr     <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      if (ctrl[L_P])       pc <= bus[ADDR_W-1:0];
      else if (ctrl[C_P])  pc <= pc + 1'b1;
      if (!ctrl[L_MA])     mar     <= bus[ADDR_W-1:0];
      if (!ctrl[L_MD])     mdr     <= bus;
      if (!ctrl[L_I])      ir      <= bus;
      if (!ctrl[L_A])      a_reg   <= bus;
      if (!ctrl[L_B])      b_reg   <= bus;
      if (!ctrl[L_O])      out_reg <= bus;
      if (ctrl[E_U] && !ctrl[L_A]) begin
        flag_c <= alu_c;
        flag_z <= alu_z;
      end
    end
  end

  // RAM has no reset so the host can load it while rst_n is held low.
  always_ff @(posedge clk) begin
    if (prog_we)        mem[prog_addr] <= prog_data;
    else if (!ctrl[L_R]) mem[mar]      <= mdr;
  end

  assign opcode   = ir[DATA_W-1 -: 4];
  assign out_data = out_reg;
  assign bus_dbg  = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// Self-checking bench for sap_datapath: directed scenarios plus random
// control words, compared each cycle against a behavioural model.
module tb_sap_datapath;
  import sap_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [14:0]   ctrl = CTRL_IDLE;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [DW-1:0] prog_data = '0;
  logic [3:0]    opcode;
  logic          flag_c, flag_z, bus_conflict;
  logic [DW-1:0] out_data, bus_dbg;

  always #5 clk = ~clk;

  sap_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ctrl         (ctrl),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .out_data     (out_data),
    .bus_dbg      (bus_dbg),
    .bus_conflict (bus_conflict)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference state
  int unsigned m_pc, m_mar, m_mdr, m_ir, m_a, m_b, m_out, m_fc, m_fz;
  int unsigned m_mem [16];

  function automatic int unsigned hi(input int unsigned b);
    return 32'd1 << b;
  endfunction

  function automatic logic [14:0] act(input int unsigned highs, input int unsigned lows);
    return 15'((32'(CTRL_IDLE) | highs) & ~lows);
  endfunction

  function automatic void model_zero();
    m_pc = 0; m_mar = 0; m_mdr = 0; m_ir = 0;
    m_a = 0; m_b = 0; m_out = 0; m_fc = 0; m_fz = 0;
  endfunction

  function automatic int unsigned alu_val(input logic [14:0] c);
    return c[S_U] ? (m_a + 256 - m_b) % 256 : (m_a + m_b) % 256;
  endfunction

  function automatic int unsigned alu_carry(input logic [14:0] c);
    return c[S_U] ? int'(m_a >= m_b) : int'(m_a + m_b > 255);
  endfunction

  function automatic void model_bus(input logic [14:0] c, output int unsigned bus,
                                    output int unsigned nd);
    nd = int'(c[E_P]) + int'(!c[CE]) + int'(!c[E_I]) + int'(c[E_A]) + int'(c[E_U]);
    if (c[E_U])       bus = alu_val(c);
    else if (c[E_A])  bus = m_a;
    else if (!c[CE])  bus = m_mem[m_mar];
    else if (!c[E_I]) bus = m_ir % 16;
    else if (c[E_P])  bus = m_pc;
    else              bus = 0;
  endfunction

  function automatic void model_edge(input logic [14:0] c, input logic r, input logic pwe,
                                     input int unsigned pa, input int unsigned pd,
                                     input int unsigned bus);
    int unsigned res, cy;
    res = alu_val(c);
    cy  = alu_carry(c);
    if (pwe)         m_mem[pa] = pd;
    else if (!c[L_R]) m_mem[m_mar] = m_mdr;
    if (!r) begin
      model_zero();
      return;
    end
    if (c[L_P])      m_pc = bus % 16;
    else if (c[C_P]) m_pc = (m_pc + 1) % 16;
    if (!c[L_MA]) m_mar = bus % 16;
    if (!c[L_MD]) m_mdr = bus;
    if (!c[L_I])  m_ir  = bus;
    if (!c[L_A])  m_a   = bus;
    if (!c[L_B])  m_b   = bus;
    if (!c[L_O])  m_out = bus;
    if (c[E_U] && !c[L_A]) begin
      m_fc = cy;
      m_fz = int'(res == 0);
    end
  endfunction

  task automatic cycle(input logic [14:0] c, input logic r, input logic pwe,
                       input int unsigned pa, input int unsigned pd);
    int unsigned bus, nd;
    @(negedge clk);
    rst_n = r; ctrl = c; prog_we = pwe;
    prog_addr = AW'(pa); prog_data = DW'(pd);
    #1;
    model_bus(c, bus, nd);
    check("bus", bus_dbg, bus);
    check("conflict", bus_conflict, int'(nd > 1));
    check("opcode", opcode, m_ir / 16);
    check("flag_c", flag_c, m_fc);
    check("flag_z", flag_z, m_fz);
    check("out_data", out_data, m_out);
    @(posedge clk);
    model_edge(c, r, pwe, pa, pd, bus);
  endtask

  task automatic step(input logic [14:0] c);
    cycle(c, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic host(input int unsigned a, input int unsigned d);
    cycle(CTRL_IDLE, 1'b1, 1'b1, a, d);
  endtask

  // Inject a value onto the bus by rewriting RAM at the current MAR, then reading it.
  task automatic put(input int unsigned v, input int unsigned highs, input int unsigned lows);
    host(m_mar, v);
    step(act(highs, hi(CE) | lows));
  endtask

  task automatic async_reset();
    @(negedge clk);
    ctrl = act(hi(E_A), 0);
    prog_we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_zero();
    check("arst_bus", bus_dbg, 0);
    check("arst_opcode", opcode, 0);
    check("arst_out", out_data, 0);
    check("arst_flags", {flag_c, flag_z}, 0);
    repeat (2) cycle(CTRL_IDLE, 1'b0, 1'b0, 0, 0);
    step(CTRL_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] c;
    #1 rst_n = 1'b0;
    model_zero();
    for (int unsigned i = 0; i < 16; i++)
      cycle(CTRL_IDLE, 1'b0, 1'b1, i, (i == 0) ? 32'h2E : $urandom_range(0, 255));
    repeat (10) step(CTRL_IDLE);

    step(act(hi(E_P), 0));
    #2;
    check("rst_pc", bus_dbg, 0);
    check("rst_opcode", opcode, 0);
    check("rst_out", out_data, 0);

    // Fetch
    step(act(hi(E_P), hi(L_MA)));
    step(act(hi(C_P), hi(CE) | hi(L_I)));
    #2 check("fetch_opcode", opcode, 2);
    step(act(hi(E_P), 0));
    #2 check("fetch_pc", bus_dbg, 1);
    step(act(0, hi(CE)));
    #2 check("fetch_mar_ram", bus_dbg, 8'h2E);

    // Add with wrap
    put(8'hF0, 0, hi(L_A));
    put(8'h20, 0, hi(L_B));
    step(act(hi(E_U), hi(L_A)));
    #2;
    check("add_c", flag_c, 1);
    check("add_z", flag_z, 0);
    step(act(hi(E_A), hi(L_O)));
    #2;
    check("add_a", bus_dbg, 8'h10);
    check("add_out", out_data, 8'h10);

    // Subtract to zero
    put(8'h05, 0, hi(L_A));
    put(8'h05, 0, hi(L_B));
    step(act(hi(S_U) | hi(E_U), hi(L_A)));
    #2;
    check("sub_z", flag_z, 1);
    check("sub_c", flag_c, 1);
    step(act(hi(E_A), 0));
    #2 check("sub_a", bus_dbg, 0);

    // Store
    put(8'h3C, 0, hi(L_A));
    put(8'h09, 0, hi(L_MA));
    host(9, 0);
    step(act(hi(E_A), hi(L_MD)));
    step(act(0, hi(L_R)));
    step(act(0, hi(CE) | hi(L_B)));
    #2 check("store_ram", bus_dbg, 8'h3C);
    step(act(hi(E_U), 0));
    #2 check("store_b_sum", bus_dbg, 8'h78);

    // Jump, conflict, PC wrap
    put(8'h7B, 0, hi(L_I));
    #2 check("jmp_opcode", opcode, 7);
    step(act(hi(L_P) | hi(C_P), hi(E_I)));
    step(act(hi(E_P), 0));
    #2 check("jmp_pc", bus_dbg, 8'h0B);
    step(act(hi(E_A) | hi(E_P), 0));
    #2;
    check("conf_flag", bus_conflict, 1);
    check("conf_bus", bus_dbg, 8'h3C);
    put(8'h0F, hi(L_P), 0);
    step(act(hi(C_P), 0));
    step(act(hi(E_P), 0));
    #2 check("pc_wrap", bus_dbg, 0);

    // Random control words, with a mid-run asynchronous reset
    for (int unsigned i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      c = 15'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        c[E_P] = 1'b0; c[CE] = 1'b1; c[E_I] = 1'b1; c[E_A] = 1'b0; c[E_U] = 1'b0;
        case ($urandom_range(0, 5))
          0: c[E_P] = 1'b1;
          1: c[CE]  = 1'b0;
          2: c[E_I] = 1'b0;
          3: c[E_A] = 1'b1;
          4: c[E_U] = 1'b1;
          default: ;
        endcase
      end
      cycle(c, 1'b1, ($urandom_range(0, 7) == 0), $urandom_range(0, 15), $urandom_range(0, 255));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Execution datapath driven by the 15-bit control word from the CPU's control sequencer; it is the consuming end of that control interface.
- Holds PC, MAR, MDR, 16x8 RAM, IR, A, B, adder/subtractor and output register, all on one shared 8-bit bus.
- Returns the current opcode (IR[7:4]) and ALU flags to the sequencer.
- Provides a host program-load port so RAM can be preloaded while the CPU is halted.

Parameters:
- DATA_W, 8, bus, register and RAM word width.
- ADDR_W, 4, PC/MAR/operand width; RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- ctrl  in  15  control word. Bit 14 C_P, 13 E_P, 12 L_P, 11 /L_MA, 10 /L_MD, 9 /CE, 8 /L_R, 7 /L_I, 6 /E_I, 5 /L_A, 4 E_A, 3 S_U, 2 E_U, 1 /L_B, 0 /L_O.
- prog_we  in  1  host RAM write strobe.
- prog_addr  in  ADDR_W  host write address.
- prog_data  in  DATA_W  host write data.
- opcode  out  4  IR[7:4].
- flag_c  out  1  registered adder carry-out.
- flag_z  out  1  registered result-is-zero flag.
- out_data  out  DATA_W  output register contents.
- bus_dbg  out  DATA_W  combinational bus value.
- bus_conflict  out  1  combinational; high when more than one bus driver is active.

Behaviour:
- Reset (async, rst_n=0): PC, MAR, MDR, IR, A, B, OUT, flag_c and flag_z all clear to 0. RAM contents are not reset. All outputs read 0 except bus_dbg, which follows the bus.
- Idle word: 15'b000111111100011 means no drivers, no loads, no increment. The datapath must hold every register under it.
- Bus drivers (combinational):
  - E_P: {0000, PC}
  - /CE=0: RAM[MAR]
  - /E_I=0: {0000, IR[3:0]}
  - E_A: A
  - E_U: ALU result
- Bus with no driver reads 8'h00.
- Multiple drivers: bus_conflict=1 and the bus takes the highest-priority driver. Priority order: E_U, E_A, /CE, /E_I, E_P.
- ALU: result = S_U ? A - B : A + B, computed in DATA_W+1 bits.
  - carry = bit DATA_W. For subtract this is the not-borrow of A + ~B + 1.
  - Wrap-around modulo 2**DATA_W.
- Posedge loads, all sampling the same pre-edge bus value:
  - L_P: PC <= bus[3:0]
  - /L_MA: MAR <= bus[3:0]
  - /L_MD: MDR <= bus
  - /L_I: IR <= bus
  - /L_A: A <= bus
  - /L_B: B <= bus
  - /L_O: OUT <= bus
- C_P: PC <= PC+1, wrapping 15 -> 0. L_P has priority over C_P when both are set.
- /L_R=0: RAM[MAR] <= MDR, using the pre-edge MDR and MAR values.
  - A simultaneous /L_MD updates MDR for the next write only.
  - RAM read during a same-edge write returns the old data.
- Flags: flag_c and flag_z update only on edges where E_U=1 and /L_A=0 (ALU result written back to A); otherwise they hold.
- Host port: prog_we writes RAM[prog_addr] <= prog_data at posedge.
  - prog_we has priority over /L_R on the same edge.
  - The host drives it only while the sequencer is halted or in reset, and it is functional during rst_n=0.
- Reset mid-operation: registers clear immediately and asynchronously, with no partial update on release. The first posedge after release behaves normally.
- Latency: a register load is visible on its output one cycle after the edge. opcode changes the cycle after /L_I.

Decomposition:
- Shared package sap_pkg holds:
  - the control-bit index constants (C_P..L_O, values 14..0);
  - the opcode constants HLT=0, NOP=1, ADD=2, SUB=3, LDA=4, OUT=5, STA=6, JMP=7;
  - CTRL_IDLE = 15'h0FE3.
- The control sequencer also imports sap_pkg.
- Natural sub-module: sap_alu (combinational add/sub with carry and zero).
- The RAM stays inline as a register array.

Test Plan:
- Reset: preload RAM[0]=8'h2E, drive ctrl=CTRL_IDLE, release rst_n -> PC=0, opcode=0, out_data=0, and all registers hold for 10 cycles.
- Fetch: E_P+/L_MA, then /CE+/L_I with C_P -> MAR=0, IR=8'h2E, opcode=2, PC=1.
- Add with wrap: A=8'hF0, B=8'h20, E_U+/L_A -> A=8'h10, flag_c=1, flag_z=0. Then /L_O+E_A -> out_data=8'h10.
- Subtract to zero: A=8'h05, B=8'h05, S_U+E_U+/L_A -> A=0, flag_z=1, flag_c=1.
- Store: MAR=9, /L_MD with E_A (A=8'h3C), then /L_R -> RAM[9]=8'h3C. A read via /CE+/L_B gives B=8'h3C.
- Jump and conflict:
  - /E_I+L_P+C_P with IR=8'h7B -> PC=4'hB (load wins over increment).
  - E_A and E_P together -> bus_conflict=1 and bus=A.
  - PC=15 with C_P -> PC=0.
